cpu_state_sequencer: RTL

//  Generates the 2-bit CPU cycle state that the instruction decoder consumes.

---
 rtl/cpu_state_pkg.sv | 27 ++
 rtl/wrap_counter.sv | 26 ++
 rtl/cpu_state_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_state_pkg.sv
// Cycle-state encodings shared by the sequencer and the instruction decoder.
package cpu_state_pkg;

  localparam logic [1:0] ST_FETCH = 2'b00;
  localparam logic [1:0] ST_EXEC1 = 2'b10;
  localparam logic [1:0] ST_EXEC2 = 2'b01;
  localparam logic [1:0] ST_IDLE  = 2'b11;

  typedef enum logic [2:0] {
    FSM_FETCH = 3'd0,
    FSM_EXEC1 = 3'd1,
    FSM_EXEC2 = 3'd2,
    FSM_PAUSE = 3'd3,
    FSM_HALT  = 3'd4
  } fsm_t;

  // PAUSE and HALT share ST_IDLE so the decoder keeps all its outputs inactive.
  function automatic logic [1:0] state_code(fsm_t s);
    case (s)
      FSM_FETCH: return ST_FETCH;
      FSM_EXEC1: return ST_EXEC1;
      FSM_EXEC2: return ST_EXEC2;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Free-running W-bit counter with synchronous reset; advances by one when en is high, wraps silently.
module wrap_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (en) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/cpu_state_sequencer.sv
// CPU cycle sequencer: FETCH -> EXEC1 -> (EXEC2) with wait states, pause/step, halt and fetch-timeout fault.
// All outputs registered; 2 cycles per simple instruction, 3 with EXEC2, plus memory wait cycles.
module cpu_state_sequencer
  import cpu_state_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int WAIT_LIMIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sm_extra,
  input  logic             halt_req,
  input  logic             mem_ready,
  input  logic             run_mode,
  input  logic             step,
  input  logic             resume,
  output logic [1:0]       state,
  output logic             halted,
  output logic             fault,
  output logic             instr_retired,
  output logic [CNT_W-1:0] retired_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

  fsm_t              fsm_d, fsm_q;
  logic [1:0]        state_d, state_q;
  logic              halted_d, halted_q;
  logic              fault_d, fault_q;
  logic              retired_d, retired_q;
  logic [WAIT_W-1:0] wait_d, wait_q;
  logic              active;
  fsm_t              next_after_exec;

  assign next_after_exec = run_mode ? FSM_FETCH : FSM_PAUSE;
  assign active = (fsm_q == FSM_FETCH) || (fsm_q == FSM_EXEC1) || (fsm_q == FSM_EXEC2);

  always_comb begin
    fsm_d     = fsm_q;
    fault_d   = fault_q;
    wait_d    = '0;
    retired_d = 1'b0;
    case (fsm_q)
      FSM_FETCH: begin
        if (mem_ready) begin
          fsm_d = FSM_EXEC1;
        end else if ((WAIT_LIMIT != 0) && (wait_q == WAIT_W'(WAIT_LIMIT - 1))) begin
          // This cycle is the WAIT_LIMIT-th consecutive miss.
          fsm_d   = FSM_HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      FSM_EXEC1: begin
        if (halt_req) begin
          fsm_d     = FSM_HALT;
          retired_d = 1'b1;
        end else if (sm_extra) begin
          fsm_d = FSM_EXEC2;
        end else begin
          fsm_d     = next_after_exec;
          retired_d = 1'b1;
        end
      end
      FSM_EXEC2: begin
        fsm_d     = next_after_exec;
        retired_d = 1'b1;
      end
      FSM_PAUSE: begin
        if (step || run_mode) fsm_d = FSM_FETCH;
      end
      FSM_HALT: begin
        if (resume) begin
          fsm_d   = FSM_FETCH;
          fault_d = 1'b0;
        end
      end
      default: fsm_d = FSM_FETCH;
    endcase
    state_d  = state_code(fsm_d);
    halted_d = (fsm_d == FSM_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= FSM_FETCH;
      state_q   <= ST_FETCH;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      retired_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

  wrap_counter #(.W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (retired_d),
    .count (retired_count)
  );

  wrap_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (active),
    .count (cycle_count)
  );

  assign state         = state_q;
  assign halted        = halted_q;
  assign fault         = fault_q;
  assign instr_retired = retired_q;

endmodule
